// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths and memory FSM state encoding for the CPU memory path
package cpu_mem_pkg;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2, HOLD = 2'd3} state_t;
endpackage

// File: rtl/memory_unit_if.sv
// memory_unit_if: request/response bus between the control path and the memory unit
interface memory_unit_if #(
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DATA_W
) ();
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] Mdatain;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] Mdataout;
    logic              done;
    logic              err;
    modport master (output addr, Mdatain, read, write, input Mdataout, done, err);
    modport slave (input addr, Mdatain, read, write, output Mdataout, done, err);
endinterface

// File: rtl/memory_unit_mem_array.sv
// mem_array: word storage with synchronous write and registered read; only the read register resets
module mem_array #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (we) mem[addr[IW-1:0]] <= wdata;
    end
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) rdata <= '0;
        else if (re) rdata <= mem[addr[IW-1:0]];
    end
endmodule

// File: rtl/memory_unit.sv
// memory_unit: wait-state memory responder with done/err handshake and single service per held request
module memory_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W      = cpu_mem_pkg::DATA_W,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input logic         clock,
    input logic         clear,
    memory_unit_if.slave bus
);
    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              op_q, done_q, err_q, oob, req, error, accept, access;
    if (DEPTH < 2**ADDR_W) begin : g_oob
        assign oob = bus.addr >= ADDR_W'(DEPTH);
    end else begin : g_full
        assign oob = 1'b0;
    end
    always_comb begin
        req      = bus.read ^ bus.write;
        error    = state == IDLE && ((bus.read && bus.write) || (req && oob));
        accept   = state == IDLE && req && !oob;
        access   = state == WAIT && cnt == 4'd0;
        state_nx = state == IDLE ? (error ? HOLD : accept ? WAIT : IDLE) :
                   state == WAIT ? (access ? DONE : WAIT) :
                   (bus.read || bus.write) ? HOLD : IDLE;
        cnt_nx   = accept ? 4'(WAIT_CYCLES) : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    end
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            op_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            done_q <= access;
            err_q  <= error;
            if (accept) begin
                addr_q <= bus.addr;
                data_q <= bus.Mdatain;
                op_q   <= bus.write;
            end
        end
    end
    mem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clock (clock),
        .clear (clear),
        .we    (access && op_q),
        .re    (access && !op_q),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (bus.Mdataout)
    );
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule
